hex_entry_controller: RTL and testbench
=======================================

// Module: hex_entry_controller
// PURPOSE
//  Sequences nibble-by-nibble entry of a DIGITS-wide hex word from switch input into a shift-free, MSB-first register.
//  Handles load, backspace, clear and commit requests from upstream debounced pushbuttons.
//  Presents the finished word to downstream logic (seven-segment driver, ALU operand) with a valid/ready handshake.
//  Sits between the button debouncers and the operand consumers.
// PARAMETERS
//  DIGITS  4  number of hex nibbles per word; must be >= 2
//  NIB_W   4  bits per digit
// PORTS
//  clk        in   1                 system clock, all logic on rising edge
//  reset_n    in   1                 asynchronous, active-low reset
//  nib_in     in   NIB_W             digit value from switches, sampled on a load_req cycle
//  load_req   in   1                 1-cycle pulse: enter nib_in at the current position
//  bksp_req   in   1                 1-cycle pulse: remove the last entered digit
//  clear_req  in   1                 1-cycle pulse: discard all digits and abort any commit
//  commit_req in   1                 1-cycle pulse: offer the entered word downstream
//  out_ready  in   1                 downstream accepts out_data when out_valid=1
//  value      out  DIGITS*NIB_W      live entry register; unentered nibbles read 0
//  cnt        out  $clog2(DIGITS+1)  number of digits entered, 0..DIGITS
//  full       out  1                 cnt==DIGITS
//  out_data   out  DIGITS*NIB_W      committed word, stable while out_valid=1
//  out_valid  out  1                 committed word pending
//  err        out  1                 1-cycle pulse on an illegal or ignored request
// BEHAVIOUR
//  Reset: state=EMPTY; value, cnt, out_data, out_valid, err all 0; full=0.
//  States:
//   EMPTY:  cnt==0
//   ENTRY:  0<cnt<DIGITS
//   FULL:   cnt==DIGITS
//   COMMIT: out_valid=1
//  Request priority within one cycle: clear > commit > bksp > load.
//   Lower-priority requests in the same cycle are dropped silently (no err).
//  load (EMPTY/ENTRY):
//   - value[(DIGITS-1-cnt)*NIB_W +: NIB_W] <= nib_in; cnt++.
//   - Moves to FULL when cnt reaches DIGITS.
//  load in FULL: value unchanged; err=1.
//  bksp:
//   - cnt>0: cnt--; the nibble at the new cnt position is cleared to 0; state follows cnt.
//   - cnt==0: err=1.
//  commit:
//   - cnt>0: out_data <= value; out_valid<=1; go to COMMIT.
//   - cnt==0: err=1.
//  COMMIT:
//   - out_ready=1 completes the transfer in that cycle: next cycle out_valid=0, value=0, cnt=0, state=EMPTY.
//   - load, bksp and commit are ignored with err=1.
//  clear in any state: next cycle value=0, cnt=0, out_valid=0, state=EMPTY.
//   - out_data keeps its last value. No err.
//  Latency: all outputs update on the clock edge after the request; err is a registered pulse.
//  reset_n asserted mid-entry or mid-commit: immediate return to reset values.
//   - A pending handshake is dropped.
// CONFIGURATION
//  Macro HEX_ENTRY_AUTO_COMMIT_EN:
//   - Defined: the load that fills the last digit also commits.
//     The next cycle has cnt==DIGITS and out_valid=1, state COMMIT.
//     commit_req still works for partial words.
//   - Undefined: the block reaches FULL and waits for commit_req.
// STRUCTURE
//  Shared package hex_entry_pkg holds:
//   - state encoding typedef: EMPTY, ENTRY, FULL, COMMIT
//   - DIGITS/NIB_W defaults
//   - a request-priority encode typedef: REQ_NONE, REQ_LOAD, REQ_BKSP, REQ_COMMIT, REQ_CLEAR
//  One sub-module, hex_req_arbiter: combinational priority encode of the four request pulses into the request typedef.
//  The FSM, entry register and handshake stay in this module.
// TESTING (DIGITS=4)
//  1. Reset, load A,B,C,D, then commit_req with out_ready=0 for 3 cycles, then 1.
//     -> value 0xABCD, full=1; out_valid held with out_data=0xABCD; cnt=0, value=0 after accept.
//  2. Load 1,2, bksp, load 7, commit with out_ready=1.
//     -> value 0x1000 after bksp; out_data=0x1700.
//  3. bksp or commit at cnt==0; load while FULL; load during COMMIT.
//     -> err pulses exactly 1 cycle each; no state change.
//  4. load_req+commit_req in one cycle at cnt=2; then clear_req+commit_req in one cycle.
//     -> commit wins, value unchanged; then clear wins, out_valid=0, cnt=0.
//  5. reset_n low mid-COMMIT.
//     -> all outputs 0 asynchronously.
//  6. HEX_ENTRY_AUTO_COMMIT_EN defined, load 4 digits.
//     -> out_valid=1 the cycle after the 4th load; undefined build -> FULL, out_valid=0.

Source files
------------

// File: rtl/hex_entry_pkg.sv
// Shared types and defaults for the hex entry controller and its request arbiter.
package hex_entry_pkg;

   localparam int DIGITS_DEF = 4;
   localparam int NIB_W_DEF  = 4;

   // Control state of the entry controller.
   typedef enum logic [1:0] {
      EMPTY,
      ENTRY,
      FULL,
      COMMIT
   } state_e;

   // The single request that wins arbitration in a cycle.
   typedef enum logic [2:0] {
      REQ_NONE,
      REQ_LOAD,
      REQ_BKSP,
      REQ_COMMIT,
      REQ_CLEAR
   } req_e;

endpackage

// File: rtl/hex_req_arbiter.sv
// Priority encode of the four button pulses: clear > commit > bksp > load.
// Losing requests in the same cycle are simply not reported.
module hex_req_arbiter
   import hex_entry_pkg::*;
(
   input  logic load_req,
   input  logic bksp_req,
   input  logic clear_req,
   input  logic commit_req,
   output req_e req
);

   // Pick the highest-priority request asserted this cycle.
   always_comb begin
      req = REQ_NONE;
      if (clear_req)       req = REQ_CLEAR;
      else if (commit_req) req = REQ_COMMIT;
      else if (bksp_req)   req = REQ_BKSP;
      else if (load_req)   req = REQ_LOAD;
   end

endmodule

// File: rtl/hex_entry_controller.sv
// Nibble-by-nibble hex word entry, MSB first, with backspace/clear and a
// valid/ready commit toward downstream consumers.
// Optional feature macro: HEX_ENTRY_AUTO_COMMIT_EN -- the load that fills the
// last digit also commits the word.
module hex_entry_controller
   import hex_entry_pkg::*;
#(
   parameter  int DIGITS = DIGITS_DEF,
   parameter  int NIB_W  = NIB_W_DEF,
   localparam int CW     = $clog2(DIGITS + 1),
   localparam int W      = DIGITS * NIB_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NIB_W-1:0] nib_in,
   input  logic             load_req,
   input  logic             bksp_req,
   input  logic             clear_req,
   input  logic             commit_req,
   input  logic             out_ready,
   output logic [W-1:0]     value,
   output logic [CW-1:0]    cnt,
   output logic             full,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   output logic             err
);

   localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

   state_e          state_q, state_n;
   logic [W-1:0]    value_q, value_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [W-1:0]    odata_q, odata_n;
   logic            err_q, err_n;
   req_e            req;

   // Replace the nibble at digit position pos (0 = most significant).
   // Shift/mask form keeps the position arithmetic free of part-select widths.
   function automatic logic [W-1:0] put_nib(input logic [W-1:0] v,
                                            input logic [CW-1:0] pos,
                                            input logic [NIB_W-1:0] n);
      int sh;
      sh = (DIGITS - 1 - int'(pos)) * NIB_W;
      return (v & ~({{(W-NIB_W){1'b0}}, {NIB_W{1'b1}}} << sh))
           | ({{(W-NIB_W){1'b0}}, n} << sh);
   endfunction

   hex_req_arbiter u_arb (
      .load_req   (load_req),
      .bksp_req   (bksp_req),
      .clear_req  (clear_req),
      .commit_req (commit_req),
      .req        (req)
   );

   // State, entry register, committed word and error pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         value_q <= '0;
         cnt_q   <= '0;
         odata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         value_q <= value_n;
         cnt_q   <= cnt_n;
         odata_q <= odata_n;
         err_q   <= err_n;
      end
   end

   // Next state and datapath for the winning request.
   always_comb begin
      state_n = state_q;
      value_n = value_q;
      cnt_n   = cnt_q;
      odata_n = odata_q;
      err_n   = 1'b0;
      if (req == REQ_CLEAR) begin
         // out_data deliberately keeps its last value.
         state_n = EMPTY;
         value_n = '0;
         cnt_n   = '0;
      end else if (state_q == COMMIT) begin
         // Transfer completes on ready; any other request is refused.
         if (out_ready) begin
            state_n = EMPTY;
            value_n = '0;
            cnt_n   = '0;
         end
         if (req != REQ_NONE) err_n = 1'b1;
      end else begin
         case (req)
            REQ_COMMIT: begin
               if (cnt_q != '0) begin
                  odata_n = value_q;
                  state_n = COMMIT;
               end else begin
                  err_n = 1'b1;
               end
            end
            REQ_BKSP: begin
               if (cnt_q != '0) begin
                  cnt_n   = cnt_q - 1'b1;
                  value_n = put_nib(value_q, cnt_n, '0);
                  state_n = (cnt_n == '0) ? EMPTY : ENTRY;
               end else begin
                  err_n = 1'b1;
               end
            end
            REQ_LOAD: begin
               if (cnt_q == CNT_MAX) begin
                  err_n = 1'b1;
               end else begin
                  value_n = put_nib(value_q, cnt_q, nib_in);
                  cnt_n   = cnt_q + 1'b1;
                  if (cnt_n == CNT_MAX) begin
`ifdef HEX_ENTRY_AUTO_COMMIT_EN
                     odata_n = value_n;
                     state_n = COMMIT;
`else
                     state_n = FULL;
`endif
                  end else begin
                     state_n = ENTRY;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign value     = value_q;
   assign cnt       = cnt_q;
   assign full      = (cnt_q == CNT_MAX);
   assign out_data  = odata_q;
   assign out_valid = (state_q == COMMIT);
   assign err       = err_q;

endmodule

// File: tb/tb_hex_entry_controller.sv
// Bench for hex_entry_controller (DIGITS=4): vector table, hand sequences for
// multi-cycle corners, and randomized pulses against a digit-queue model.
module tb_hex_entry_controller;

   localparam int D = 4;
`ifdef HEX_ENTRY_AUTO_COMMIT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  nib_in = '0;
   logic        load_req = 1'b0, bksp_req = 1'b0, clear_req = 1'b0, commit_req = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] value, out_data;
   logic [2:0]  cnt;
   logic        full, out_valid, err;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the entered digits in order, a pending-commit flag, the last committed word.
   int          mq[$];
   bit          m_pend;
   logic [15:0] m_od;
   bit          m_err;

   hex_entry_controller #(.DIGITS(D), .NIB_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .nib_in     (nib_in),
      .load_req   (load_req),
      .bksp_req   (bksp_req),
      .clear_req  (clear_req),
      .commit_req (commit_req),
      .out_ready  (out_ready),
      .value      (value),
      .cnt        (cnt),
      .full       (full),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ld, bk, cl, cm, rdy;
      logic [3:0]  nib;
      logic [15:0] ev;
      int          ec;
      logic        eov;
      logic [15:0] eod;
      logic        eerr;
   } vec_t;

   vec_t tbl[15];

   function automatic logic [15:0] mval();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < mq.size(); i++) v = v | (16'(mq[i]) << ((D - 1 - i) * 4));
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pend = 1'b0;
      m_od   = '0;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input bit ld, bk, cl, cm, rdy, input logic [3:0] nib);
      m_err = 1'b0;
      if (cl) begin
         mq.delete();
         m_pend = 1'b0;
      end else if (m_pend) begin
         if (rdy) begin
            mq.delete();
            m_pend = 1'b0;
         end
         if (cm || bk || ld) m_err = 1'b1;
      end else if (cm) begin
         if (mq.size() > 0) begin m_od = mval(); m_pend = 1'b1; end
         else m_err = 1'b1;
      end else if (bk) begin
         if (mq.size() > 0) void'(mq.pop_back());
         else m_err = 1'b1;
      end else if (ld) begin
         if (mq.size() == D) m_err = 1'b1;
         else begin
            mq.push_back(int'(nib));
            if (AUTO && mq.size() == D) begin m_od = mval(); m_pend = 1'b1; end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] ev, input int ec,
                          input logic eov, input logic [15:0] eod, input logic eerr);
      chk({tag, " value"},     32'(value),     32'(ev));
      chk({tag, " cnt"},       32'(cnt),       ec);
      chk({tag, " full"},      32'(full),      32'(ec == D));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(eov));
      chk({tag, " out_data"},  32'(out_data),  32'(eod));
      chk({tag, " err"},       32'(err),       32'(eerr));
   endtask

   // Drive one cycle of requests, advance the model, sample 1 time unit after the edge.
   task automatic apply(input bit ld, bk, cl, cm, rdy, input logic [3:0] nib);
      load_req = ld; bksp_req = bk; clear_req = cl; commit_req = cm;
      out_ready = rdy; nib_in = nib;
      model_step(ld, bk, cl, cm, rdy, nib);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      load_req = 0; bksp_req = 0; clear_req = 0; commit_req = 0; out_ready = 0;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      // Test 2 then tests 3/4, from reset: {ld,bk,cl,cm,rdy,nib, value,cnt,ov,odata,err}
      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h1, 16'h1000,1,1'b0,16'h0000,1'b0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h2, 16'h1200,2,1'b0,16'h0000,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0, 16'h1000,1,1'b0,16'h0000,1'b0};
      tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h7, 16'h1700,2,1'b0,16'h0000,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,4'h0, 16'h1700,2,1'b1,16'h1700,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,4'h0, 16'h0000,0,1'b0,16'h1700,1'b0};
      tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'h0, 16'h0000,0,1'b0,16'h1700,1'b1};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,4'h0, 16'h0000,0,1'b0,16'h1700,1'b1};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 16'h0000,0,1'b0,16'h1700,1'b0};
      tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h3, 16'h3000,1,1'b0,16'h1700,1'b0};
      tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h4, 16'h3400,2,1'b0,16'h1700,1'b0};
      tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,4'h5, 16'h3400,2,1'b1,16'h3400,1'b0};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0,4'h0, 16'h0000,0,1'b0,16'h3400,1'b0};
      tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'h9, 16'h9000,1,1'b0,16'h3400,1'b0};
      tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,4'hF, 16'h0000,0,1'b0,16'h3400,1'b0};

      do_reset();
      chk_out("reset", 16'h0, 0, 1'b0, 16'h0, 1'b0);

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].ld, tbl[i].bk, tbl[i].cl, tbl[i].cm, tbl[i].rdy, tbl[i].nib);
         chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].eov, tbl[i].eod, tbl[i].eerr);
      end

      // Fill A,B,C,D; FULL (or auto-commit) behaviour, held handshake, accept.
      do_reset();
      apply(1,0,0,0,0,4'hA); apply(1,0,0,0,0,4'hB); apply(1,0,0,0,0,4'hC);
      chk_out("fill3", 16'hABC0, 3, 1'b0, 16'h0, 1'b0);
      apply(1,0,0,0,0,4'hD);
      chk_out("fill4", 16'hABCD, 4, AUTO, AUTO ? 16'hABCD : 16'h0, 1'b0);
      apply(1,0,0,0,0,4'hE);
      chk_out("load_full", 16'hABCD, 4, AUTO, AUTO ? 16'hABCD : 16'h0, 1'b1);
      apply(0,0,0,0,0,4'h0);
      chk_out("err_drop", 16'hABCD, 4, AUTO, AUTO ? 16'hABCD : 16'h0, 1'b0);
      apply(0,0,0,1,0,4'h0);
      chk_out("commit", 16'hABCD, 4, 1'b1, 16'hABCD, AUTO);
      for (int i = 0; i < 3; i++) begin
         apply(0,0,0,0,0,4'h0);
         chk_out($sformatf("hold%0d", i), 16'hABCD, 4, 1'b1, 16'hABCD, 1'b0);
      end
      apply(1,0,0,0,0,4'h1);
      chk_out("load_commit", 16'hABCD, 4, 1'b1, 16'hABCD, 1'b1);
      apply(0,1,0,0,1,4'h0);
      chk_out("accept", 16'h0, 0, 1'b0, 16'hABCD, 1'b1);
      apply(0,0,0,0,0,4'h0);
      chk_out("idle", 16'h0, 0, 1'b0, 16'hABCD, 1'b0);

      // Asynchronous reset in the middle of a pending commit.
      apply(1,0,0,0,0,4'h5);
      apply(0,0,0,1,0,4'h0);
      chk_out("pre_rst", 16'h5000, 1, 1'b1, 16'h5000, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_out("async_rst", 16'h0, 0, 1'b0, 16'h0, 1'b0);
      @(posedge clk); #1;
      chk_out("rst_hold", 16'h0, 0, 1'b0, 16'h0, 1'b0);
      reset_n = 1'b1;
      model_reset();

      // Random request pulses against the model.
      for (int c = 0; c < 3000; c++) begin
         apply($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
               $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 2,
               $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
         chk_out("rnd", mval(), mq.size(), m_pend, m_od, m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
